// File: rtl/round_robin_grant_scheduler.sv
// round_robin_grant_scheduler
//   Registered round-robin arbiter with a valid/ready handshake on the grant
//   side. Priority selection uses two fast_first_one instances: one on the
//   requests above the last-served index, one on the raw request vector.
//
//   Optional feature macro: ROUND_ROBIN_GRANT_SCHEDULER_LOCK_EN (adds `lock`).
//
//   Parameters:
//     REQUESTERS   number of requesters (>= 2)
//     INDEX_WIDTH  derived width of grant_index
//   Ports:
//     clock        in   system clock, rising edge
//     reset        in   asynchronous active-high reset
//     requests     in   [REQUESTERS] level-sensitive request per requester
//     grant        out  [REQUESTERS] one-hot grant, zero when not valid
//     grant_index  out  [INDEX_WIDTH] binary index of grant, zero when not valid
//     grant_valid  out  a grant is being presented
//     grant_ready  in   resource accepts/completes the current grant
//     lock         in   (LOCK_EN only) keep current owner at handshake

// Isolates the lowest set bit of a vector and encodes its position.
//   i_vec     in   vector to search
//   o_onehot  out  lowest set bit of i_vec, zero if none
//   o_index   out  binary position of o_onehot
//   o_found   out  i_vec has at least one bit set
module fast_first_one #(
  parameter  int WIDTH = 8,
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [WIDTH-1:0] o_onehot,
  output logic [IW-1:0]    o_index,
  output logic             o_found
);

  always_comb begin
    // Two's-complement trick: x & -x keeps only the lowest set bit.
    o_onehot = i_vec & (~i_vec + WIDTH'(1));
    o_found  = |i_vec;
    o_index  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (o_onehot[i]) begin
        o_index = o_index | IW'(i);
      end
    end
  end

endmodule

module round_robin_grant_scheduler #(
  parameter  int REQUESTERS  = 8,
  localparam int INDEX_WIDTH = $clog2(REQUESTERS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [REQUESTERS-1:0]  requests,
  output logic [REQUESTERS-1:0]  grant,
  output logic [INDEX_WIDTH-1:0] grant_index,
  output logic                   grant_valid,
`ifdef ROUND_ROBIN_GRANT_SCHEDULER_LOCK_EN
  input  logic                   lock,
`endif
  input  logic                   grant_ready
);

  typedef enum logic {
    IDLE,
    GRANTED
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;

  logic [REQUESTERS-1:0]  r_grant;
  logic [INDEX_WIDTH-1:0] r_grant_index;
  logic [INDEX_WIDTH-1:0] r_last_index;

  logic [REQUESTERS-1:0]  w_grant_next;
  logic [INDEX_WIDTH-1:0] w_grant_index_next;
  logic [INDEX_WIDTH-1:0] w_last_index_next;

  logic                   w_handshake;
  logic                   w_any_request;
  logic                   w_hold_lock;
  logic [INDEX_WIDTH-1:0] w_base;
  logic [REQUESTERS-1:0]  w_mask;
  logic [REQUESTERS-1:0]  w_masked_requests;

  logic [REQUESTERS-1:0]  w_masked_onehot;
  logic [INDEX_WIDTH-1:0] w_masked_index;
  logic                   w_masked_found;
  logic [REQUESTERS-1:0]  w_raw_onehot;
  logic [INDEX_WIDTH-1:0] w_raw_index;
  logic                   w_raw_found;

  logic [REQUESTERS-1:0]  w_cand_onehot;
  logic [INDEX_WIDTH-1:0] w_cand_index;

  assign w_handshake   = (r_state == GRANTED) && grant_ready;
  assign w_any_request = |requests;

`ifdef ROUND_ROBIN_GRANT_SCHEDULER_LOCK_EN
  assign w_hold_lock = lock && (|(requests & r_grant));
`else
  assign w_hold_lock = 1'b0;
`endif

  // During a handshake the requester being released is already the lowest
  // priority, before last_index has caught up.
  assign w_base = w_handshake ? r_grant_index : r_last_index;

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      w_mask[i] = (i > 32'(w_base));
    end
  end

  assign w_masked_requests = requests & w_mask;

  fast_first_one #(.WIDTH(REQUESTERS)) u_ffo_masked (
    .i_vec    (w_masked_requests),
    .o_onehot (w_masked_onehot),
    .o_index  (w_masked_index),
    .o_found  (w_masked_found)
  );

  fast_first_one #(.WIDTH(REQUESTERS)) u_ffo_raw (
    .i_vec    (requests),
    .o_onehot (w_raw_onehot),
    .o_index  (w_raw_index),
    .o_found  (w_raw_found)
  );

  // Wrap around to the raw vector when nothing sits above the base.
  always_comb begin
    w_cand_onehot = '0;
    w_cand_index  = '0;
    if (w_masked_found) begin
      w_cand_onehot = w_masked_onehot;
      w_cand_index  = w_masked_index;
    end else if (w_raw_found) begin
      w_cand_onehot = w_raw_onehot;
      w_cand_index  = w_raw_index;
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_any_request) begin
          w_state_next = GRANTED;
        end
      end
      GRANTED: begin
        if (w_handshake && !w_hold_lock && !w_any_request) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output/datapath next values
  always_comb begin
    w_grant_next       = r_grant;
    w_grant_index_next = r_grant_index;
    w_last_index_next  = r_last_index;
    case (r_state)
      IDLE: begin
        if (w_any_request) begin
          w_grant_next       = w_cand_onehot;
          w_grant_index_next = w_cand_index;
        end
      end
      GRANTED: begin
        if (w_handshake && !w_hold_lock) begin
          w_last_index_next = r_grant_index;
          if (w_any_request) begin
            w_grant_next       = w_cand_onehot;
            w_grant_index_next = w_cand_index;
          end else begin
            w_grant_next       = '0;
            w_grant_index_next = '0;
          end
        end
      end
      default: begin
        w_grant_next       = '0;
        w_grant_index_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_grant       <= '0;
      r_grant_index <= '0;
      r_last_index  <= INDEX_WIDTH'(REQUESTERS - 1);
    end else begin
      r_grant       <= w_grant_next;
      r_grant_index <= w_grant_index_next;
      r_last_index  <= w_last_index_next;
    end
  end

  assign grant       = r_grant;
  assign grant_index = r_grant_index;
  assign grant_valid = (r_state == GRANTED);

endmodule

// File: tb/tb_round_robin_grant_scheduler.sv
module tb_round_robin_grant_scheduler;

  localparam int N = 4;

  logic         clock;
  logic         reset;
  logic [N-1:0] requests;
  logic [N-1:0] grant;
  logic [1:0]   grant_index;
  logic         grant_valid;
  logic         grant_ready;
`ifdef ROUND_ROBIN_GRANT_SCHEDULER_LOCK_EN
  logic         lock;
`endif

  int n_checks;
  int n_fail;

  round_robin_grant_scheduler #(.REQUESTERS(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .requests    (requests),
    .grant       (grant),
    .grant_index (grant_index),
    .grant_valid (grant_valid),
`ifdef ROUND_ROBIN_GRANT_SCHEDULER_LOCK_EN
    .lock        (lock),
`endif
    .grant_ready (grant_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_grant(input string tag, input logic [N-1:0] g,
                              input logic [1:0] idx, input logic v);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".index"}, 32'(grant_index), 32'(idx));
    check({tag, ".valid"}, 32'(grant_valid), 32'(v));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Expected index sequence with all four requesting and ready held high.
  logic [1:0] rr_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    requests    = '0;
    grant_ready = 1'b0;
`ifdef ROUND_ROBIN_GRANT_SCHEDULER_LOCK_EN
    lock        = 1'b0;
`endif
    step();
    step();
    expect_grant("reset", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;

    // Single grant held while the resource is busy.
    requests = 4'b1010;
    step();
    expect_grant("first", 4'b0010, 2'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_grant("hold", 4'b0010, 2'd1, 1'b1);
    end

    // Back-to-back rotation from reset priority.
    do_reset();
    requests    = 4'b1111;
    grant_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr.index", 32'(grant_index), 32'(rr_seq[i]));
      check("rr.valid", 32'(grant_valid), 32'd1);
    end

    // Requester 2 granted, drops its request while the grant is held.
    requests = 4'b0100;
    step();
    expect_grant("g2", 4'b0100, 2'd2, 1'b1);
    grant_ready = 1'b0;
    requests    = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_grant("g2hold", 4'b0100, 2'd2, 1'b1);
    end
    requests    = 4'b0000;
    grant_ready = 1'b1;
    step();
    expect_grant("toidle", 4'b0000, 2'd0, 1'b0);
    step();
    expect_grant("idleready", 4'b0000, 2'd0, 1'b0);

    // Sole requester 3 re-granted, then requester 0 takes over.
    requests = 4'b1000;
    step();
    expect_grant("solo3a", 4'b1000, 2'd3, 1'b1);
    step();
    expect_grant("solo3b", 4'b1000, 2'd3, 1'b1);
    step();
    expect_grant("solo3c", 4'b1000, 2'd3, 1'b1);
    requests = 4'b1001;
    step();
    expect_grant("wrap0", 4'b0001, 2'd0, 1'b1);

    // Asynchronous reset while requester 3 holds the grant.
    requests = 4'b1000;
    step();
    expect_grant("pre_rst", 4'b1000, 2'd3, 1'b1);
    grant_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    expect_grant("async_rst", 4'b0000, 2'd0, 1'b0);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    requests = 4'b1001;
    step();
    expect_grant("post_rst", 4'b0001, 2'd0, 1'b1);

`ifdef ROUND_ROBIN_GRANT_SCHEDULER_LOCK_EN
    do_reset();
    requests    = 4'b0011;
    lock        = 1'b1;
    grant_ready = 1'b0;
    step();
    expect_grant("lock_first", 4'b0001, 2'd0, 1'b1);
    grant_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_grant("locked", 4'b0001, 2'd0, 1'b1);
    end
    lock = 1'b0;
    step();
    expect_grant("unlock", 4'b0010, 2'd1, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/round_robin_grant_scheduler.md
# round_robin_grant_scheduler

Registered round-robin arbiter that shares one downstream resource between `REQUESTERS` requesters, with a valid/ready handshake on the grant side. Priority selection is built from two `fast_first_one` instances (masked and unmasked request vectors), so the block is the sequencing layer on top of the first-one datapath. It sits in front of any shared port (bus master interface, memory bank, execution unit) whose users must be served fairly and one at a time.

## Interface
- `REQUESTERS`, default 8, number of requesters (≥2).
- `INDEX_WIDTH`, default `$clog2(REQUESTERS)`, width of `grant_index`; derived, not overridden.

- `clock`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `requests`  input  REQUESTERS  one bit per requester, level-sensitive.
- `grant`  output  REQUESTERS  one-hot grant, all-zero when `grant_valid` low.
- `grant_index`  output  INDEX_WIDTH  binary index of granted requester, 0 when `grant_valid` low.
- `grant_valid`  output  1  a grant is being presented.
- `grant_ready`  input  1  resource accepts/completes the current grant.
- `lock`  input  1  only with `ROUND_ROBIN_GRANT_SCHEDULER_LOCK_EN`; keep current owner.

## Operation
- All outputs registered. Reset values: `grant`=0, `grant_index`=0, `grant_valid`=0; internal `last_index`=REQUESTERS-1 (requester 0 highest priority after reset).
- Priority: mask = bits strictly above `last_index`. Candidate = first one of `requests & mask`; if that is zero, first one of `requests`. Index is the binary encoding of the one-hot candidate.
- Arbitration mask uses `grant_index` instead of `last_index` in the cycle of a handshake, so the just-served requester gets lowest priority immediately.
- States: IDLE (`grant_valid`=0), GRANTED (`grant_valid`=1).
- IDLE, `requests`≠0 → GRANTED, load candidate.
- IDLE, `requests`=0 → IDLE.
- GRANTED, `grant_ready`=0 → hold; `grant`/`grant_index` stable even if the granted request drops or others rise.
- GRANTED, `grant_ready`=1 (handshake): `last_index` ← `grant_index`; if `requests`≠0 load new candidate and stay GRANTED (back-to-back, no bubble), else → IDLE.
- Granted requester still requesting at handshake is eligible but lowest priority; if it is the only requester it is re-granted.
- `grant_ready` in IDLE is ignored.

## Timing
- Request-to-grant latency: 1 cycle (request sampled at edge N, `grant_valid` high after edge N).
- Handshake at edge N; next grant visible after edge N, so one grant per cycle when `grant_ready` is held high.
- Reset asserted mid-grant: outputs clear asynchronously, `last_index` returns to REQUESTERS-1; first grant after release follows reset priority.
- Fairness bound: a continuously asserting requester is granted within REQUESTERS handshakes (lock disabled).

## Configuration
- `ROUND_ROBIN_GRANT_SCHEDULER_LOCK_EN` defined: `lock` port exists. At a handshake with `lock`=1 and the granted requester's request still high, the same grant is reloaded and `last_index` is not updated; otherwise normal arbitration. `lock` ignored outside handshakes.
- Not defined: no `lock` port; behaviour as if `lock`=0.

## Test plan
- After reset, REQUESTERS=4, `requests`=4'b1010, `grant_ready`=0 → next cycle `grant`=4'b0010, `grant_index`=1, held for 5 cycles unchanged.
- `requests`=4'b1111, `grant_ready`=1 constant → grant_index sequence 0,1,2,3,0 on consecutive cycles, no bubble.
- Granted requester 2, its request drops while `grant_ready`=0 → `grant` stays 4'b0100 until handshake; then `requests`=0 → `grant_valid`=0 next cycle.
- Only requester 3 requesting, `grant_ready`=1 → index 3 re-granted every cycle; requester 0 rises → index 0 granted after next handshake.
- Reset pulse while `grant`=4'b1000 → outputs 0 immediately; after release with `requests`=4'b1001 → `grant_index`=0.
- With `ROUND_ROBIN_GRANT_SCHEDULER_LOCK_EN`, `requests`=4'b0011, `lock`=1 on grant 0 → index 0 for 3 handshakes; `lock`=0 → index 1 next.
